// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences RV64 loads/stores over a valid/ready memory bus with lane alignment and extension
module mem_access_ctrl #(
   parameter int REG_WIDTH  = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic                    mem_sign,
   input  logic [1:0]              mem_width,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [REG_WIDTH-1:0]    wdata,
   output logic [REG_WIDTH-1:0]    rdata,
   output logic                    stall,
   output logic                    fault,
   output logic                    bus_req_valid,
   input  logic                    bus_req_ready,
   output logic                    bus_req_we,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [REG_WIDTH-1:0]    bus_wdata,
   output logic [REG_WIDTH/8-1:0]  bus_wstrb,
   input  logic                    bus_resp_valid,
   input  logic [REG_WIDTH-1:0]    bus_resp_data
);
   localparam int NB = REG_WIDTH / 8;
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t               state;
   logic [1:0]           width_q;
   logic                 sign_q;
   logic [2:0]           off_q;
   logic                 access, illegal, aligned, accept;
   logic [2:0]           amask;
   logic [NB-1:0]        lmask;
   logic [REG_WIDTH-1:0] v, ext;
   // Decode the incoming request and build the extended load value from the latched access shape
   always_comb begin
      access  = mem_read | mem_write;
      illegal = mem_read & mem_write;
      amask   = mem_width == 2'd0 ? 3'd0 : mem_width == 2'd1 ? 3'd1 : mem_width == 2'd2 ? 3'd3 : 3'd7;
      lmask   = mem_width == 2'd0 ? NB'(8'h01) : mem_width == 2'd1 ? NB'(8'h03) : mem_width == 2'd2 ? NB'(8'h0F) : NB'(8'hFF);
      aligned = (addr[2:0] & amask) == 3'd0;
      accept  = !rst && state == IDLE && access && aligned && !illegal;
      fault   = !rst && state == IDLE && access && (!aligned || illegal);
      stall   = !rst && (accept || state == REQ || state == RESP);
      v       = bus_resp_data >> {off_q, 3'b000};
      ext     = width_q == 2'd0 ? {{(REG_WIDTH-8){!sign_q & v[7]}}, v[7:0]} :
                width_q == 2'd1 ? {{(REG_WIDTH-16){!sign_q & v[15]}}, v[15:0]} :
                width_q == 2'd2 ? {{(REG_WIDTH-32){!sign_q & v[31]}}, v[31:0]} : v;
   end
   // Access FSM: latch the request in IDLE, hold it on the bus until accepted, then await data or retire
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rdata         <= '0;
         bus_req_valid <= 1'b0;
         bus_req_we    <= 1'b0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_wstrb     <= '0;
         width_q       <= '0;
         sign_q        <= 1'b0;
         off_q         <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state         <= REQ;
               bus_req_valid <= 1'b1;
               bus_req_we    <= mem_write;
               bus_addr      <= {addr[ADDR_WIDTH-1:3], 3'b000};
               bus_wdata     <= wdata << {addr[2:0], 3'b000};
               bus_wstrb     <= lmask << addr[2:0];
               width_q       <= mem_width;
               sign_q        <= mem_sign;
               off_q         <= addr[2:0];
            end
            REQ: if (bus_req_ready) begin
               bus_req_valid <= 1'b0;
               state         <= bus_req_we ? DONE : RESP;
            end
            RESP: if (bus_resp_valid) begin
               rdata <= ext;
               state <= DONE;
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
   logic        clk = 1'b0;
   logic        rst, mem_read, mem_write, mem_sign;
   logic [1:0]  mem_width;
   logic [63:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_resp_data;
   logic        stall, fault, bus_req_valid, bus_req_ready, bus_req_we, bus_resp_valid;
   logic [7:0]  bus_wstrb;
   int          n_cmp = 0;
   int          n_err = 0;

   mem_access_ctrl #(.REG_WIDTH(64), .ADDR_WIDTH(64)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_sign(mem_sign),
      .mem_width(mem_width), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [63:0] a, input logic [1:0] w, input logic s, input logic [63:0] d,
                          output logic [63:0] r, output logic [4:0] sp, output logic [63:0] ba);
      mem_read = 1'b1; addr = a; mem_width = w; mem_sign = s;
      #1 sp[4] = stall;
      tick();
      mem_read = 1'b0; addr = '0; bus_req_ready = 1'b1;
      #1 sp[3] = stall; ba = bus_addr;
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = d;
      #1 sp[2] = stall;
      tick();
      bus_resp_valid = 1'b0; bus_resp_data = '0;
      #1 sp[1] = stall; r = rdata;
      tick();
      #1 sp[0] = stall;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_read = 0; mem_write = 0; mem_sign = 0; mem_width = 0; addr = 0; wdata = 0;
      bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = 0;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({rdata, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
         n_err++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h wstrb=%h want all 0", rdata, bus_addr, bus_wdata, bus_wstrb);
      end
      n_cmp++;
      if ({stall, fault, bus_req_valid, bus_req_we} !== 4'b0000) begin
         n_err++; $display("FAIL reset_ctrl: got stall/fault/valid/we=%b want 0000", {stall, fault, bus_req_valid, bus_req_we});
      end
   endtask

   task automatic test_lb();
      logic [63:0] r, ba;
      logic [4:0]  sp;
      do_load(64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, r, sp, ba);
      n_cmp++;
      if (r !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %h want ffffffffffffff80", r); end
      n_cmp++;
      if (ba !== 64'h1000) begin n_err++; $display("FAIL lb_addr: got %h want 1000", ba); end
      do_load(64'h1003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, r, sp, ba);
      n_cmp++;
      if (r !== 64'h80) begin n_err++; $display("FAIL lbu_rdata: got %h want 80", r); end
   endtask

   task automatic test_sh_wait();
      logic [138:0] exp;
      exp = {1'b1, 1'b1, 1'b1, 64'h2000, 64'h1234_0000_0000_0000, 8'hC0};
      mem_write = 1'b1; addr = 64'h2006; mem_width = 2'd1; wdata = 64'h1234;
      #1;
      n_cmp++;
      if ({stall, bus_req_valid} !== 2'b10) begin n_err++; $display("FAIL sh_idle: got stall/valid=%b want 10", {stall, bus_req_valid}); end
      tick();
      mem_write = 1'b0; addr = '0; wdata = '1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus_req_ready = 1'b1;
         #1;
         n_cmp++;
         if ({bus_req_valid, bus_req_we, stall, bus_addr, bus_wdata, bus_wstrb} !== exp) begin
            n_err++;
            $display("FAIL sh_req%0d: got v/we/st=%b addr=%h wdata=%h wstrb=%h want 111 2000 1234000000000000 c0",
                     i, {bus_req_valid, bus_req_we, stall}, bus_addr, bus_wdata, bus_wstrb);
         end
         tick();
      end
      bus_req_ready = 1'b0;
      #1;
      n_cmp++;
      if ({stall, bus_req_valid} !== 2'b00) begin n_err++; $display("FAIL sh_done: got stall/valid=%b want 00", {stall, bus_req_valid}); end
      tick();
   endtask

   task automatic test_store_zero_wait();
      logic [3:0] sp;
      mem_write = 1'b1; addr = 64'h5005; mem_width = 2'd0; wdata = 64'hAB;
      #1 sp[3] = stall;
      tick();
      mem_write = 1'b0; bus_req_ready = 1'b1;
      #1 sp[2] = stall;
      n_cmp++;
      if ({bus_wstrb, bus_wdata, bus_addr} !== {8'h20, 64'h0000_AB00_0000_0000, 64'h5000}) begin
         n_err++; $display("FAIL sb_lanes: got wstrb=%h wdata=%h addr=%h want 20 0000ab0000000000 5000", bus_wstrb, bus_wdata, bus_addr);
      end
      tick();
      bus_req_ready = 1'b0;
      #1 sp[1] = stall;
      tick();
      #1 sp[0] = stall;
      n_cmp++;
      if (sp !== 4'b1100) begin n_err++; $display("FAIL sb_stall: got %b want 1100", sp); end
   endtask

   task automatic test_fault();
      mem_read = 1'b1; addr = 64'h1002; mem_width = 2'd2;
      #1;
      n_cmp++;
      if ({fault, stall, bus_req_valid} !== 3'b100) begin n_err++; $display("FAIL lw_misaligned: got fault/stall/valid=%b want 100", {fault, stall, bus_req_valid}); end
      tick();
      mem_read = 1'b0;
      #1;
      n_cmp++;
      if ({fault, stall, bus_req_valid, rdata} !== {3'b000, 64'h80}) begin
         n_err++; $display("FAIL lw_misaligned_after: got fault/stall/valid=%b rdata=%h want 000 80", {fault, stall, bus_req_valid}, rdata);
      end
      mem_read = 1'b1; mem_write = 1'b1; addr = 64'h1000; mem_width = 2'd3;
      #1;
      n_cmp++;
      if ({fault, stall, bus_req_valid} !== 3'b100) begin n_err++; $display("FAIL illegal: got fault/stall/valid=%b want 100", {fault, stall, bus_req_valid}); end
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      n_cmp++;
      if ({fault, stall, bus_req_valid, rdata} !== {3'b000, 64'h80}) begin
         n_err++; $display("FAIL illegal_after: got fault/stall/valid=%b rdata=%h want 000 80", {fault, stall, bus_req_valid}, rdata);
      end
   endtask

   task automatic test_ld_zero_wait();
      logic [63:0] r, ba;
      logic [4:0]  sp;
      do_load(64'h3000, 2'd3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, r, sp, ba);
      n_cmp++;
      if (r !== 64'hDEAD_BEEF_CAFE_F00D) begin n_err++; $display("FAIL ld_rdata: got %h want deadbeefcafef00d", r); end
      n_cmp++;
      if (sp !== 5'b11100) begin n_err++; $display("FAIL ld_stall: got %b want 11100", sp); end
   endtask

   task automatic test_lw();
      logic [63:0] r, ba;
      logic [4:0]  sp;
      do_load(64'h4004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, r, sp, ba);
      n_cmp++;
      if (r !== 64'hFFFF_FFFF_8765_4321) begin n_err++; $display("FAIL lw_rdata: got %h want ffffffff87654321", r); end
      do_load(64'h4004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, r, sp, ba);
      n_cmp++;
      if (r !== 64'h0000_0000_8765_4321) begin n_err++; $display("FAIL lwu_rdata: got %h want 0000000087654321", r); end
      do_load(64'h6006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, r, sp, ba);
      n_cmp++;
      if (r !== 64'hFFFF_FFFF_FFFF_8001) begin n_err++; $display("FAIL lh_rdata: got %h want ffffffffffff8001", r); end
   endtask

   task automatic test_rst_resp();
      mem_read = 1'b1; addr = 64'h3000; mem_width = 2'd3; mem_sign = 1'b0;
      tick();
      mem_read = 1'b0; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      #1;
      n_cmp++;
      if ({stall, bus_req_valid} !== 2'b10) begin n_err++; $display("FAIL rst_resp_pre: got stall/valid=%b want 10", {stall, bus_req_valid}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({stall, bus_req_valid, rdata} !== {2'b00, 64'h0}) begin
         n_err++; $display("FAIL rst_resp_post: got stall/valid=%b rdata=%h want 00 0", {stall, bus_req_valid}, rdata);
      end
      bus_resp_valid = 1'b1; bus_resp_data = 64'h1111_2222_3333_4444;
      tick();
      bus_resp_valid = 1'b0;
      tick();
      n_cmp++;
      if ({stall, rdata} !== {1'b0, 64'h0}) begin n_err++; $display("FAIL late_resp: got stall=%b rdata=%h want 0 0", stall, rdata); end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh_wait();
      test_store_zero_wait();
      test_fault();
      test_ld_zero_wait();
      test_lw();
      test_rst_resp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
